// File: rtl/mul2_fitness_pkg.sv
// Shared types and golden model for the 2x2-bit multiplier lane scorers.
package mul2_fitness_pkg;

    localparam int unsigned LANES          = 16;
    localparam int unsigned OUT_BITS       = 4;
    localparam int unsigned MAX_BEAT_SCORE = LANES * OUT_BITS;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        RESULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [LANES-1:0] g3;
        logic [LANES-1:0] g2;
        logic [LANES-1:0] g1;
        logic [LANES-1:0] g0;
    } golden_t;

    // Bit-sliced reference product of {a1,a0} * {b1,b0} for all lanes at once.
    function automatic golden_t golden(
        input logic [LANES-1:0] a1,
        input logic [LANES-1:0] a0,
        input logic [LANES-1:0] b1,
        input logic [LANES-1:0] b0
    );
        golden_t g;
        g.g0 = a0 & b0;
        g.g1 = (a1 & b0) ^ (a0 & b1);
        g.g2 = a1 & b1 & ~(a0 & b0);
        g.g3 = a1 & a0 & b1 & b0;
        return g;
    endfunction

endpackage

// File: rtl/mul2_lane_fitness_scorer_popcount64.sv
// Combinational 64-bit population count.
module popcount64 (
    input  logic [63:0] bits,
    output logic [6:0]  count
);

    // Linear sum of set bits; synthesis folds this into an adder tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < 64; i++) begin
            count = count + 7'(bits[i]);
        end
    end

endmodule

// File: rtl/mul2_lane_fitness_scorer.sv
// Scores a bit-sliced 2x2 multiplier candidate: matching output bits summed over BEATS words.
module mul2_lane_fitness_scorer
    import mul2_fitness_pkg::*;
#(
    parameter  int unsigned BEATS   = 1,
    localparam int unsigned SCORE_W = $clog2(64 * BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        a1,
    input  logic [15:0]        a0,
    input  logic [15:0]        b1,
    input  logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] score,
    output logic               perfect
);

    localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned FULL_SCORE = MAX_BEAT_SCORE * BEATS;

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic               s1_valid;
    logic               s2_valid;
    logic [63:0]        s1_match;
    logic [6:0]         s2_count;
    logic [6:0]         pc_count;
    logic [SCORE_W-1:0] acc;
    golden_t            gold;
    logic               accept;

    assign accept = in_valid && in_ready;
    assign gold   = golden(a1, a0, b1, b0);
    assign score  = acc;

    popcount64 u_popcount (
        .bits  (s1_match),
        .count (pc_count)
    );

    // Pipeline data: S1 holds per-bit match flags, S2 holds the beat's match count.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_match <= ~({y3, y2, y1, y0} ^ gold);
        end
        s2_count <= pc_count;
    end

    // Control FSM, pipeline valids and score accumulator; abort behaves like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            perfect   <= 1'b0;
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc       <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (s2_valid) begin
                acc <= acc + SCORE_W'(s2_count);
            end
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (beat_cnt == CNT_W'(BEATS - 1)) begin
                            beat_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Both stages empty means the final add has already landed in acc.
                    if (!s1_valid && !s2_valid) begin
                        state     <= RESULT;
                        out_valid <= 1'b1;
                        perfect   <= (acc == SCORE_W'(FULL_SCORE));
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        perfect   <= 1'b0;
                        in_ready  <= 1'b1;
                        beat_cnt  <= '0;
                        acc       <= '0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul2_lane_fitness_scorer.sv
// Directed bench for mul2_lane_fitness_scorer with BEATS=1 and BEATS=4 instances.
`timescale 1ns/1ps
module tb_mul2_lane_fitness_scorer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;

    logic        v1, ir1, ab1, ov1, or1, pf1;
    logic [6:0]  sc1;
    logic        v4, ir4, ab4, ov4, or4, pf4;
    logic [8:0]  sc4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul2_lane_fitness_scorer #(.BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .abort(ab1), .out_valid(ov1), .out_ready(or1),
        .score(sc1), .perfect(pf1)
    );

    mul2_lane_fitness_scorer #(.BEATS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .abort(ab4), .out_valid(ov4), .out_ready(or4),
        .score(sc4), .perfect(pf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // kind 0: correct products, 1: all-zero y, 2: all-one y (exhaustive operand word)
    task automatic set_beat(input int kind);
        a0 = 16'hAAAA; a1 = 16'hCCCC; b0 = 16'hF0F0; b1 = 16'hFF00;
        case (kind)
            0:       begin y0 = 16'hA0A0; y1 = 16'h6AC0; y2 = 16'h4C00; y3 = 16'h8000; end
            1:       begin y0 = 16'h0000; y1 = 16'h0000; y2 = 16'h0000; y3 = 16'h0000; end
            default: begin y0 = 16'hFFFF; y1 = 16'hFFFF; y2 = 16'hFFFF; y3 = 16'hFFFF; end
        endcase
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 0; ab1 = 0; or1 = 0;
        v4 = 0; ab4 = 0; or4 = 0;
        set_beat(0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_out_valid", 32'(ov1), 0);
        check("rst_in_ready", 32'(ir1), 1);
        check("rst_score", 32'(sc1), 0);
        check("rst_perfect", 32'(pf1), 0);
        check("rst_in_ready4", 32'(ir4), 1);

        // BEATS=1 correct beat: out_valid exactly three cycles after accept
        set_beat(0);
        v1 = 1;
        tick();
        v1 = 0;
        check("b1_in_ready_drain", 32'(ir1), 0);
        tick();
        tick();
        check("b1_valid_early", 32'(ov1), 0);
        tick();
        check("b1_valid", 32'(ov1), 1);
        check("b1_score", 32'(sc1), 64);
        check("b1_perfect", 32'(pf1), 1);
        or1 = 1;
        tick();
        or1 = 0;
        check("b1_release_valid", 32'(ov1), 0);
        check("b1_release_ready", 32'(ir1), 1);

        // BEATS=1 all-zero candidate
        set_beat(1);
        v1 = 1;
        tick();
        v1 = 0;
        tick();
        tick();
        tick();
        check("zero_valid", 32'(ov1), 1);
        check("zero_score", 32'(sc1), 50);
        check("zero_perfect", 32'(pf1), 0);
        or1 = 1;
        tick();
        or1 = 0;

        // BEATS=4 mixed beats: 64 + 50 + 14 + 64
        v4 = 1;
        set_beat(0); tick();
        set_beat(1); tick();
        set_beat(2); tick();
        set_beat(0); tick();
        v4 = 0;
        tick();
        tick();
        check("b4_valid_early", 32'(ov4), 0);
        tick();
        check("b4_valid", 32'(ov4), 1);
        check("b4_score", 32'(sc4), 192);
        check("b4_perfect", 32'(pf4), 0);

        // Backpressure: result held, offered beats ignored
        set_beat(0);
        v4 = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(ov4), 1);
            check("bp_score", 32'(sc4), 192);
            check("bp_in_ready", 32'(ir4), 0);
        end
        v4 = 0;
        or4 = 1;
        tick();
        or4 = 0;
        check("bp_release_valid", 32'(ov4), 0);
        check("bp_release_ready", 32'(ir4), 1);
        check("bp_release_score", 32'(sc4), 0);

        // Abort after two weak beats, beat in abort cycle dropped, then four correct beats
        set_beat(1);
        v4 = 1;
        tick();
        tick();
        ab4 = 1;
        tick();
        ab4 = 0;
        v4 = 0;
        check("abort_in_ready", 32'(ir4), 1);
        check("abort_valid", 32'(ov4), 0);
        tick();
        tick();
        check("abort_score_cleared", 32'(sc4), 0);
        set_beat(0);
        v4 = 1;
        for (int i = 0; i < 4; i++) tick();
        v4 = 0;
        tick();
        tick();
        check("abort_valid_early", 32'(ov4), 0);
        tick();
        check("abort_eval_valid", 32'(ov4), 1);
        check("abort_eval_score", 32'(sc4), 256);
        check("abort_eval_perfect", 32'(pf4), 1);
        or4 = 1;
        tick();
        or4 = 0;

        // Reset during DRAIN discards the evaluation
        set_beat(1);
        v1 = 1;
        tick();
        v1 = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("rst_drain_valid", 32'(ov1), 0);
            tick();
        end
        check("rst_drain_score", 32'(sc1), 0);
        check("rst_drain_ready", 32'(ir1), 1);
        set_beat(0);
        v1 = 1;
        tick();
        v1 = 0;
        tick();
        tick();
        tick();
        check("post_rst_valid", 32'(ov1), 1);
        check("post_rst_score", 32'(sc1), 64);
        check("post_rst_perfect", 32'(pf1), 1);
        or1 = 1;
        tick();
        or1 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
